afu_flr_responder: RTL
======================

// Module: afu_flr_responder
// PURPOSE
//  Function-side endpoint of the FLR channel: consumes FLR requests routed to one AFU port, quiesces
//  that port's host TX stream at a packet boundary, and holds a per-function soft reset for a fixed time.
//  Then returns the FLR completion response. Sits in each AFU port between the FLR router and the
//  function's logic. Serves one PF and its VFs; requests are queued and processed one at a time.
// PARAMETERS
//  PF_NUM          0     PF number owned by this port; requests for other PFs are discarded
//  NUM_VF          4     VFs under PF_NUM (1..64); VF index >= NUM_VF is discarded
//  REQ_FIFO_DEPTH  4     pending-request FIFO depth (power of 2, >= 2)
//  RST_CYCLES      64    cycles the function reset is held (>= 2)
//  DRAIN_TIMEOUT   1024  max cycles waiting for TX packet boundary before forcing reset
// PORTS
//  clk               in   1       port clock
//  rst               in   1       asynchronous, active-high reset
//  flr_req_valid     in   1       one-cycle FLR request strobe (no backpressure)
//  flr_req_pf        in   3       request PF number
//  flr_req_vf        in   11      request VF number
//  flr_req_vf_active in   1       1 = VF-level FLR, 0 = PF-level FLR
//  flr_rsp_valid     out  1       one-cycle FLR completion strobe
//  flr_rsp_pf        out  3       echoed PF
//  flr_rsp_vf        out  11      echoed VF
//  flr_rsp_vf_active out  1       echoed vf_active
//  tx_tvalid         in   1       function TX tvalid (monitored, pre-gate)
//  tx_tready         in   1       downstream TX tready (monitored)
//  tx_tlast          in   1       function TX tlast
//  tx_gate           out  1       1 = block new TX packets (combine into tvalid upstream)
//  pf_flr_rst        out  1       function reset for the PF (also resets every VF)
//  vf_flr_rst        out  NUM_VF  per-VF function reset
//  flr_busy          out  1       FLR in progress or requests pending
//  err_cnt           out  16      error counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; FSM IDLE; in_pkt = 0.
//  - Filtering: a request is enqueued only when pf == PF_NUM and (!vf_active or vf < NUM_VF). Others are
//    dropped with no response. A request arriving with the FIFO full is dropped. Drops count as errors.
//  - in_pkt tracker: set on tvalid&tready&!tlast, clear on tvalid&tready&tlast. A packet boundary exists when
//    in_pkt == 0 and no beat is accepted this cycle.
//  - FSM:
//    IDLE  : FIFO non-empty -> pop to request reg, assert tx_gate, go DRAIN (1 cycle after push at earliest).
//    DRAIN : tx_gate=1; in_pkt==0 -> RESET. Timer reaches DRAIN_TIMEOUT-1 -> RESET (timeout error).
//    RESET : assert pf_flr_rst (PF FLR) or vf_flr_rst[vf] (VF FLR) for exactly RST_CYCLES cycles -> RESP.
//    RESP  : deassert resets; flr_rsp_valid=1 for one cycle with echoed fields; drop tx_gate -> IDLE.
//  - Latency: with an idle TX stream, push at cycle N gives rsp_valid at N+3+RST_CYCLES.
//  - tx_gate stays high from DRAIN through RESP. Once gated, a packet in flight may finish; its tlast
//    clears in_pkt.
//  - Simultaneous push and pop: both allowed; the FIFO count is unchanged.
//  - A duplicate request for the function currently in RESET is enqueued normally, not merged.
//  - Resets are registered outputs, glitch-free. At most one vf_flr_rst bit is high at a time.
//  - flr_busy = (state != IDLE) | fifo_not_empty.
//  - An async rst mid-FLR aborts the operation: resets and gate drop and no response is issued.
//    The upstream FLR router is reset with the same domain.
// CONFIGURATION
//  FLR_RESP_ERR_CNT_EN defined: err_cnt increments, saturating at 16'hFFFF, on filtered drop, FIFO-full
//    drop or DRAIN timeout. Events in the same cycle add separately (+1 or +2).
//  Undefined: err_cnt tied to 16'h0; no counter logic instantiated.
// TESTING
//  1 PF FLR (pf=0, vf_active=0), TX idle -> pf_flr_rst high 64 cycles, rsp echoes pf=0 at N+67.
//  2 VF FLR vf=2 issued while a 4-beat packet is mid-transfer -> gate high, packet finishes, then
//    vf_flr_rst=4'b0100 for 64 cycles, then rsp.
//  3 TX stuck mid-packet (tready=0) -> reset forced after 1024 DRAIN cycles; err_cnt=1 (macro on).
//  4 Five requests back-to-back with DEPTH=4 while first in RESET -> 4 accepted, 5th dropped,
//    4 responses in order.
//  5 Requests pf=1 and vf=7 (NUM_VF=4) -> no reset, no rsp, err_cnt=2 (macro on) / 0 (macro off).
//  6 Assert rst during RESET -> all outputs 0 next edge, FIFO empty, no rsp after release.

Source files
------------

// File: rtl/afu_flr_responder.sv
// afu_flr_responder
//  Function-side FLR endpoint for one AFU port. FLR requests for the owned PF
//  (and its VFs) are queued. Each one is then handled in turn:
//    1. gate the host TX stream at a packet boundary;
//    2. hold the PF or VF function reset for RST_CYCLES cycles;
//    3. return a one-cycle completion carrying the echoed request fields.
//  Optional macro: FLR_RESP_ERR_CNT_EN. When defined, err_cnt is a saturating
//  count of dropped requests and drain timeouts. When undefined, err_cnt is
//  tied to zero.
// Ports
//  clk, rst                   port clock, async active-high reset
//  flr_req_*                  FLR request strobe + pf/vf/vf_active (no backpressure)
//  flr_rsp_*                  FLR completion strobe + echoed fields
//  tx_tvalid/tready/tlast     monitored host TX handshake
//  tx_gate                    blocks new TX packets while an FLR is in progress
//  pf_flr_rst, vf_flr_rst     registered function resets
//  flr_busy                   FLR in progress or requests pending
//  err_cnt                    error counter
module afu_flr_responder #(
  parameter int PF_NUM         = 0,
  parameter int NUM_VF         = 4,
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int RST_CYCLES     = 64,
  parameter int DRAIN_TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flr_req_valid,
  input  logic [2:0]        flr_req_pf,
  input  logic [10:0]       flr_req_vf,
  input  logic              flr_req_vf_active,
  output logic              flr_rsp_valid,
  output logic [2:0]        flr_rsp_pf,
  output logic [10:0]       flr_rsp_vf,
  output logic              flr_rsp_vf_active,
  input  logic              tx_tvalid,
  input  logic              tx_tready,
  input  logic              tx_tlast,
  output logic              tx_gate,
  output logic              pf_flr_rst,
  output logic [NUM_VF-1:0] vf_flr_rst,
  output logic              flr_busy,
  output logic [15:0]       err_cnt
);
  localparam int AW   = $clog2(REQ_FIFO_DEPTH);
  localparam int TMAX = (DRAIN_TIMEOUT > RST_CYCLES) ? DRAIN_TIMEOUT : RST_CYCLES;
  localparam int CW   = $clog2(TMAX);

  typedef struct packed {
    logic [2:0]  pf;
    logic [10:0] vf;
    logic        vf_active;
  } flr_req_t;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RESET, S_RESP} state_t;

  state_t            state_q, state_d;
  flr_req_t          req_q, req_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              gate_q, gate_d;
  logic              pf_rst_q, pf_rst_d;
  logic [NUM_VF-1:0] vf_rst_q, vf_rst_d, vf_onehot;
  logic              rsp_q, rsp_d;
  logic              in_pkt_q;
  logic              pop, timeout;

  // ---------------- request filter + FIFO ----------------
  flr_req_t          mem_q [REQ_FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              req_match, fifo_full, fifo_empty, push, filt_drop, full_drop;

  assign req_match  = (flr_req_pf == 3'(PF_NUM)) &&
                      (!flr_req_vf_active || (flr_req_vf < 11'(NUM_VF)));
  assign fifo_full  = (count_q == (AW+1)'(REQ_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = flr_req_valid & req_match & ~fifo_full;
  assign filt_drop  = flr_req_valid & ~req_match;
  assign full_drop  = flr_req_valid & req_match & fifo_full;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pf: flr_req_pf, vf: flr_req_vf, vf_active: flr_req_vf_active};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // ---------------- TX packet tracker ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     in_pkt_q <= 1'b0;
    else if (tx_tvalid && tx_tready && !tx_tlast) in_pkt_q <= 1'b1;
    else if (tx_tvalid && tx_tready &&  tx_tlast) in_pkt_q <= 1'b0;
  end

  // ---------------- FSM ----------------
  always_comb begin
    vf_onehot = '0;
    for (int i = 0; i < NUM_VF; i++) vf_onehot[i] = (req_q.vf == 11'(i));
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cnt_d    = cnt_q;
    gate_d   = gate_q;
    pf_rst_d = pf_rst_q;
    vf_rst_d = vf_rst_q;
    rsp_d    = 1'b0;
    pop      = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        req_d   = mem_q[rd_ptr_q];
        gate_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A clean boundary takes priority over a coincident timeout.
        timeout = in_pkt_q && (cnt_q == CW'(DRAIN_TIMEOUT - 1));
        if (!in_pkt_q || timeout) begin
          cnt_d    = '0;
          pf_rst_d = ~req_q.vf_active;
          vf_rst_d = req_q.vf_active ? vf_onehot : '0;
          state_d  = S_RESET;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESET: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) begin
          pf_rst_d = 1'b0;
          vf_rst_d = '0;
          rsp_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        gate_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      gate_q   <= 1'b0;
      pf_rst_q <= 1'b0;
      vf_rst_q <= '0;
      rsp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      gate_q   <= gate_d;
      pf_rst_q <= pf_rst_d;
      vf_rst_q <= vf_rst_d;
      rsp_q    <= rsp_d;
    end
  end

  assign tx_gate           = gate_q;
  assign pf_flr_rst        = pf_rst_q;
  assign vf_flr_rst        = vf_rst_q;
  assign flr_rsp_valid     = rsp_q;
  assign flr_rsp_pf        = req_q.pf;
  assign flr_rsp_vf        = req_q.vf;
  assign flr_rsp_vf_active = req_q.vf_active;
  assign flr_busy          = (state_q != S_IDLE) | ~fifo_empty;

  // ---------------- error counter ----------------
`ifdef FLR_RESP_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  // filt_drop and full_drop are exclusive, so at most +2 per cycle.
  assign err_inc = 2'(filt_drop) + 2'(full_drop) + 2'(timeout);
  assign err_sum = {1'b0, err_cnt_q} + 17'(err_inc);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
  assign err_cnt = err_cnt_q;
`else
  logic unused_err;
  assign unused_err = filt_drop ^ full_drop ^ timeout;
  assign err_cnt    = 16'h0;
`endif
endmodule
